wheel_motor_driver: RTL

//  Downstream stage of the Renee controller: converts one 3-bit one-hot wheel action code
//  (lwa or rwa) into motor-driver signals (PWM, direction, brake).

---
 rtl/wheel_motor_driver_pkg.sv | 17 +
 rtl/wheel_motor_driver_if.sv | 14 +
 rtl/wheel_motor_driver_pwm_gen.sv | 26 ++
 rtl/wheel_motor_driver.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/wheel_motor_driver_pkg.sv
// Shared action codes and FSM state encoding for the wheel motor drivers.
// The display and the top level reuse these same codes.
package wheel_motor_driver_pkg;

   localparam logic [2:0] ActRev  = 3'b100;
   localparam logic [2:0] ActFwd  = 3'b010;
   localparam logic [2:0] ActStop = 3'b001;

   typedef enum logic [2:0] {
      StIdle     = 3'b000,
      StRampUp   = 3'b001,
      StRun      = 3'b010,
      StRampDown = 3'b011,
      StDead     = 3'b100
   } state_e;

endpackage

// File: rtl/wheel_motor_driver_if.sv
// Wheel action command in, motor-driver signals and debug/status out.
interface wheel_motor_driver_if #(
   parameter int unsigned PWM_BITS = 8
);
   logic [2:0]          action;
   logic                pwm;
   logic                dir;
   logic                brake;
   logic [PWM_BITS-1:0] duty;
   logic [2:0]          state;

   modport master (output action, input pwm, dir, brake, duty, state);
   modport slave  (input action, output pwm, dir, brake, duty, state);
endinterface

// File: rtl/wheel_motor_driver_pwm_gen.sv
// Free-running PWM counter and comparator with a registered output.
module wheel_motor_driver_pwm_gen #(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic [PWM_BITS-1:0] duty,
   output logic                pwm
);

   logic [PWM_BITS-1:0] cnt_q;
   logic                pwm_q;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_q + PWM_BITS'(1);
         pwm_q <= (cnt_q < duty);
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/wheel_motor_driver.sv
// One-hot wheel action to PWM/dir/brake, with soft start/stop ramps and a
// brake-only dead time that every direction reversal must pass through.
module wheel_motor_driver
   import wheel_motor_driver_pkg::*;
#(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned MAX_DUTY    = 255,
   parameter int unsigned RAMP_STEP   = 16,
   parameter int unsigned RAMP_DIV    = 50000,
   parameter int unsigned DEAD_CYCLES = 1000
) (
   input logic                 CLOCK_50,
   input logic                 resetn,
   wheel_motor_driver_if.slave bus
);

   localparam int unsigned PresW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [PWM_BITS:0]   StepW   = (PWM_BITS + 1)'(RAMP_STEP);
   localparam logic [PWM_BITS:0]   MaxW    = (PWM_BITS + 1)'(MAX_DUTY);
   localparam logic [PWM_BITS-1:0] MaxDuty = PWM_BITS'(MAX_DUTY);

   logic [2:0]          act_meta_q, act_s_q;
   logic [PresW-1:0]    presc_q;
   logic                tick;
   state_e              state_q, state_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [DeadW-1:0]    dead_q, dead_d;
   logic                dir_q, dir_d;
   logic                brake_q, brake_d;
   logic                cmd_fwd, cmd_rev, cmd_same;
   logic [PWM_BITS:0]   duty_up, duty_dn;
   logic [PWM_BITS-1:0] duty_up_sat, duty_dn_sat, duty_gated;
   logic                pwm;

   // action is asynchronous to CLOCK_50
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         act_meta_q <= ActStop;
         act_s_q    <= ActStop;
         presc_q    <= '0;
      end else begin
         act_meta_q <= bus.action;
         act_s_q    <= act_meta_q;
         presc_q    <= tick ? '0 : presc_q + PresW'(1);
      end
   end

   assign tick     = (presc_q == PresW'(RAMP_DIV - 1));
   assign cmd_fwd  = (act_s_q == ActFwd);
   assign cmd_rev  = (act_s_q == ActRev);
   assign cmd_same = dir_q ? cmd_fwd : cmd_rev;

   // One extra bit so the ramp saturates instead of wrapping
   assign duty_up     = {1'b0, duty_q} + StepW;
   assign duty_dn     = {1'b0, duty_q} - StepW;
   assign duty_up_sat = (duty_up >= MaxW) ? MaxDuty : duty_up[PWM_BITS-1:0];
   assign duty_dn_sat = ({1'b0, duty_q} <= StepW) ? '0 : duty_dn[PWM_BITS-1:0];

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         duty_q  <= '0;
         dead_q  <= '0;
         dir_q   <= 1'b1;
         brake_q <= 1'b1;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         dead_q  <= dead_d;
         dir_q   <= dir_d;
         brake_q <= brake_d;
      end
   end

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      dead_d  = dead_q;
      dir_d   = dir_q;
      unique case (state_q)
         StIdle: begin
            duty_d = '0;
            dead_d = '0;
            if (cmd_fwd || cmd_rev) begin
               dir_d   = cmd_fwd;
               state_d = StRampUp;
            end
         end
         StRampUp: begin
            if (!cmd_same) begin
               state_d = StRampDown;
            end else if (tick) begin
               duty_d = duty_up_sat;
               if (duty_up_sat == MaxDuty) state_d = StRun;
            end
         end
         StRun: begin
            duty_d = MaxDuty;
            if (!cmd_same) state_d = StRampDown;
         end
         StRampDown: begin
            if (cmd_same) begin
               state_d = StRampUp;
            end else if (tick) begin
               duty_d = duty_dn_sat;
               if (duty_dn_sat == '0) begin
                  state_d = StDead;
                  dead_d  = '0;
               end
            end
         end
         StDead: begin
            duty_d = '0;
            if (dead_q == DeadW'(DEAD_CYCLES - 1)) begin
               state_d = StIdle;
               dead_d  = '0;
            end else begin
               dead_d = dead_q + DeadW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            duty_d  = '0;
            dead_d  = '0;
         end
      endcase
   end

   always_comb begin
      brake_d = (state_d == StIdle) || (state_d == StDead);
   end

   assign duty_gated = brake_q ? '0 : duty_q;

   wheel_motor_driver_pwm_gen #(
      .PWM_BITS(PWM_BITS)
   ) u_pwm_gen (
      .CLOCK_50(CLOCK_50),
      .resetn  (resetn),
      .duty    (duty_gated),
      .pwm     (pwm)
   );

   assign bus.pwm   = pwm;
   assign bus.dir   = dir_q;
   assign bus.brake = brake_q;
   assign bus.duty  = duty_q;
   assign bus.state = state_q;

endmodule
